stopwatch_ctrl: RTL and testbench

Button-driven control FSM for the three-digit BCD stopwatch. It synchronizes and debounces two raw push-buttons, start/stop and lap/reset, and turns them into single-cycle press events. From those events it generates the stopwatch's `go` enable and its active-low synchronous clear. It also holds a lap snapshot of the digits and muxes either the live or the frozen value onto the display outputs feeding the 7-segment decoders.

---
 rtl/stopwatch_ctrl.sv | 150 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Button front end and control FSM for the three-digit BCD stopwatch: synchronize,
// debounce and edge-detect two buttons, then drive go/clear, lap freeze and display mux.
module stopwatch_ctrl #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned DB_W      = 20
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    output logic       go,
    output logic       sw_clr,
    output logic       lap_act,
    output logic [3:0] disp0,
    output logic [3:0] disp1,
    output logic [3:0] disp2
);

    localparam int unsigned NBTN = 2;
    localparam int unsigned DIG_W = 4;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } state_t;

    // Bit 0 = start/stop, bit 1 = lap/reset.
    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] s1;
    logic [NBTN-1:0] s2;
    logic [NBTN-1:0] stable;
    logic [NBTN-1:0] stable_d;
    logic [NBTN-1:0] press;
    logic [DB_W-1:0] cnt [NBTN];

    logic ss_ev;
    logic lr_ev;

    state_t state_q;
    state_t state_d;
    logic   clr_pulse;
    logic   capture;

    logic [3*DIG_W-1:0] lap_reg;

    assign raw = {btn_lr, btn_ss};

    // Synchronizer, debounce counter and press edge detector for both buttons.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < NBTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1       <= raw;
            s2       <= s1;
            stable_d <= stable;
            for (int i = 0; i < NBTN; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign press = stable & ~stable_d;
    assign ss_ev = press[0];
    assign lr_ev = press[1];

    // State register plus outputs decoded from the next state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            go      <= 1'b0;
            sw_clr  <= 1'b0;
            lap_act <= 1'b0;
            lap_reg <= '0;
        end else begin
            state_q <= state_d;
            go      <= (state_d == RUN) || (state_d == LAP);
            sw_clr  <= ~clr_pulse;
            lap_act <= (state_d == LAP);
            if (capture) begin
                lap_reg <= {d2, d1, d0};
            end
        end
    end

    // Next state; start/stop takes priority when both events land together.
    always_comb begin
        state_d   = state_q;
        clr_pulse = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_ev) begin
                    state_d = RUN;
                end else if (lr_ev) begin
                    clr_pulse = 1'b1;
                end
            end
            RUN: begin
                if (ss_ev) begin
                    state_d = STOP;
                end else if (lr_ev) begin
                    state_d = LAP;
                    capture = 1'b1;
                end
            end
            LAP: begin
                if (ss_ev) begin
                    state_d = STOP;
                end else if (lr_ev) begin
                    state_d = RUN;
                end
            end
            STOP: begin
                if (ss_ev) begin
                    state_d = RUN;
                end else if (lr_ev) begin
                    state_d   = IDLE;
                    clr_pulse = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign disp0 = lap_act ? lap_reg[DIG_W-1:0]         : d0;
    assign disp1 = lap_act ? lap_reg[2*DIG_W-1:DIG_W]   : d1;
    assign disp2 = lap_act ? lap_reg[3*DIG_W-1:2*DIG_W] : d2;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short debounce window (DB_CYCLES=4).
module tb_stopwatch_ctrl;

    logic       clk;
    logic       clr;
    logic       btn_ss;
    logic       btn_lr;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic       go;
    logic       sw_clr;
    logic       lap_act;
    logic [3:0] disp0;
    logic [3:0] disp1;
    logic [3:0] disp2;

    int errors = 0;
    int checks = 0;

    stopwatch_ctrl #(
        .DB_CYCLES(4),
        .DB_W     (3)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .btn_ss (btn_ss),
        .btn_lr (btn_lr),
        .d0     (d0),
        .d1     (d1),
        .d2     (d2),
        .go     (go),
        .sw_clr (sw_clr),
        .lap_act(lap_act),
        .disp0  (disp0),
        .disp1  (disp1),
        .disp2  (disp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Press (and hold long enough to fire), then release and let the release settle.
    task automatic push(input logic ss, input logic lr);
        btn_ss = ss;
        btn_lr = lr;
        repeat (7) tick();
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        repeat (8) tick();
    endtask

    // An lr press from IDLE or STOP: sw_clr low for exactly the one cycle after edge 6.
    task automatic clear_press(input string tag);
        btn_lr = 1'b1;
        repeat (6) tick();
        chk({tag, "_pre"}, {11'd0, sw_clr}, 12'd1);
        tick();
        chk({tag, "_low"}, {11'd0, sw_clr}, 12'd0);
        chk({tag, "_go"}, {11'd0, go}, 12'd0);
        tick();
        chk({tag, "_high"}, {11'd0, sw_clr}, 12'd1);
        btn_lr = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        clr    = 1'b1;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        d0     = 4'd5;
        d1     = 4'd0;
        d2     = 4'd0;
        repeat (2) tick();
        clr = 1'b0;
        repeat (3) tick();

        // Mid-cycle reset takes effect immediately.
        #3;
        clr = 1'b1;
        #1;
        chk("rst_go", {11'd0, go}, 12'd0);
        chk("rst_swclr", {11'd0, sw_clr}, 12'd0);
        chk("rst_lap", {11'd0, lap_act}, 12'd0);
        chk("rst_disp", {disp2, disp1, disp0}, 12'h005);
        tick();
        clr = 1'b0;
        chk("rst_swclr_hold", {11'd0, sw_clr}, 12'd0);
        tick();
        chk("rst_swclr_rise", {11'd0, sw_clr}, 12'd1);

        // Start latency: first sampled at edge 0, go rises at edge 6.
        btn_ss = 1'b1;
        repeat (6) tick();
        chk("start_early", {11'd0, go}, 12'd0);
        tick();
        chk("start_go", {11'd0, go}, 12'd1);
        repeat (100) tick();
        chk("hold_go", {11'd0, go}, 12'd1);
        btn_ss = 1'b0;
        repeat (8) tick();
        chk("release_go", {11'd0, go}, 12'd1);
        push(1'b1, 1'b0);
        chk("stop_go", {11'd0, go}, 12'd0);
        push(1'b1, 1'b0);
        chk("resume_go", {11'd0, go}, 12'd1);

        // Bounce on lr: pattern 1,1,0,1,1,1... restarts the window; event at edge 9.
        d0     = 4'd3;
        d1     = 4'd2;
        d2     = 4'd1;
        btn_lr = 1'b1;
        tick();
        tick();
        btn_lr = 1'b0;
        tick();
        btn_lr = 1'b1;
        repeat (4) tick();
        chk("bounce_no_early", {11'd0, lap_act}, 12'd0);
        repeat (2) tick();
        chk("bounce_pre", {11'd0, lap_act}, 12'd0);
        tick();
        chk("lap_act", {11'd0, lap_act}, 12'd1);
        chk("lap_disp", {disp2, disp1, disp0}, 12'h123);
        d0 = 4'd7;
        d1 = 4'd8;
        d2 = 4'd9;
        tick();
        chk("lap_frozen", {disp2, disp1, disp0}, 12'h123);
        chk("lap_go", {11'd0, go}, 12'd1);
        btn_lr = 1'b0;
        repeat (8) tick();
        push(1'b0, 1'b1);
        chk("unlap_act", {11'd0, lap_act}, 12'd0);
        chk("unlap_disp", {disp2, disp1, disp0}, 12'h987);
        chk("unlap_go", {11'd0, go}, 12'd1);

        // Stop then clear, then a second clear from IDLE.
        push(1'b1, 1'b0);
        chk("stop2_go", {11'd0, go}, 12'd0);
        clear_press("clr_stop");
        clear_press("clr_idle");
        push(1'b1, 1'b0);
        chk("idle_start", {11'd0, go}, 12'd1);

        // Simultaneous presses in RUN: ss wins.
        btn_ss = 1'b1;
        btn_lr = 1'b1;
        repeat (7) tick();
        chk("simul_go", {11'd0, go}, 12'd0);
        chk("simul_lap", {11'd0, lap_act}, 12'd0);
        chk("simul_swclr", {11'd0, sw_clr}, 12'd1);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        repeat (8) tick();

        // Reset while frozen on a lap.
        push(1'b1, 1'b0);
        d0 = 4'd1;
        d1 = 4'd1;
        d2 = 4'd1;
        push(1'b0, 1'b1);
        chk("lap2_act", {11'd0, lap_act}, 12'd1);
        d0 = 4'd4;
        d1 = 4'd5;
        d2 = 4'd6;
        chk("lap2_disp", {disp2, disp1, disp0}, 12'h111);
        #3;
        clr = 1'b1;
        #1;
        chk("frz_rst_lap", {11'd0, lap_act}, 12'd0);
        chk("frz_rst_go", {11'd0, go}, 12'd0);
        chk("frz_rst_disp", {disp2, disp1, disp0}, 12'h654);
        tick();
        clr = 1'b0;
        tick();
        chk("frz_rst_swclr", {11'd0, sw_clr}, 12'd1);
        push(1'b1, 1'b0);
        chk("post_rst_start", {11'd0, go}, 12'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
